// File: rtl/instr_fetch.sv
// Fetch stage: reads the word at the current IP, hands it to the decoder over
// valid/ready, and issues exactly one IP update per accepted instruction.
module instr_fetch #(
  parameter int WORD_SIZE  = 16,
  parameter int INSTR_STEP = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic        [WORD_SIZE-1:0] ip,
  output logic                        mem_req,
  output logic        [WORD_SIZE-1:0] mem_addr,
  input  logic                        mem_ack,
  input  logic        [WORD_SIZE-1:0] mem_data,
  output logic        [WORD_SIZE-1:0] instr,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  input  logic                        branch_take,
  input  logic signed [WORD_SIZE-1:0] branch_adj,
  input  logic                        flush,
  output logic                        ip_update,
  output logic signed [WORD_SIZE-1:0] ip_adj
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  localparam logic signed [WORD_SIZE-1:0] STEP = WORD_SIZE'(INSTR_STEP);

  state_t                 state, state_nxt;
  logic   [WORD_SIZE-1:0] addr_nxt;
  logic   [WORD_SIZE-1:0] instr_nxt;
  logic                   accept;

  // Request and valid flags decode straight from the state register.
  assign mem_req     = (state == REQ);
  assign instr_valid = (state == HOLD);

  // The IP moves on the same edge the word leaves; flush always wins.
  assign accept    = instr_valid && instr_ready && !flush;
  assign ip_update = accept;
  assign ip_adj    = branch_take ? branch_adj : STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      instr    <= '0;
    end else begin
      state    <= state_nxt;
      mem_addr <= addr_nxt;
      instr    <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    instr_nxt = instr;
    case (state)
      IDLE: begin
        if (enable && !flush) begin
          state_nxt = REQ;
          addr_nxt  = ip;
        end
      end
      REQ: begin
        // A read already on the bus cannot be withdrawn, so a flush without
        // the ack must wait for it in DRAIN.
        if (mem_ack) begin
          if (flush) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            instr_nxt = mem_data;
          end
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (flush || instr_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run
// against a transaction-level model of memory, decoder and instruction pointer.
module tb_instr_fetch;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic        [15:0] ip;
  logic               mem_req;
  logic        [15:0] mem_addr;
  logic               mem_ack;
  logic        [15:0] mem_data;
  logic        [15:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_take;
  logic signed [15:0] branch_adj;
  logic               flush;
  logic               ip_update;
  logic signed [15:0] ip_adj;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;

  instr_fetch #(.WORD_SIZE(16), .INSTR_STEP(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ip(ip),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_take(branch_take), .branch_adj(branch_adj), .flush(flush),
    .ip_update(ip_update), .ip_adj(ip_adj)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ip_update === 1'b1) upd_cnt <= upd_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Randomized-phase model state
  logic [15:0] ipm, word, eadj, nip;
  bit          have, busy, xfl, acc, ack;
  int          cnt, base;

  initial begin
    reset = 1'b1; enable = 1'b0; ip = '0; mem_ack = 1'b0; mem_data = '0;
    instr_ready = 1'b0; branch_take = 1'b0; branch_adj = '0; flush = 1'b0;
    tick();
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_ip_update", {15'd0, ip_update}, 16'd0);
    reset = 1'b0;

    // 1: async reset in the middle of a request; a late ack is ignored
    ip = 16'h0030; enable = 1'b1;
    tick();
    chk("t1_req", {15'd0, mem_req}, 16'd1);
    chk("t1_addr", mem_addr, 16'h0030);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_req", {15'd0, mem_req}, 16'd0);
    chk("t1_async_valid", {15'd0, instr_valid}, 16'd0);
    chk("t1_async_addr", mem_addr, 16'h0000);
    #1 reset = 1'b0; enable = 1'b0; mem_ack = 1'b1; mem_data = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("t1_late_ack_valid", {15'd0, instr_valid}, 16'd0);
    chk("t1_late_ack_req", {15'd0, mem_req}, 16'd0);

    // 2: basic fetch and accept
    base = upd_cnt;
    ip = 16'h0010; enable = 1'b1;
    tick();
    chk("t2_addr", mem_addr, 16'h0010);
    chk("t2_req", {15'd0, mem_req}, 16'd1);
    enable = 1'b0; mem_ack = 1'b1; mem_data = 16'hA5A5;
    tick();
    mem_ack = 1'b0;
    chk("t2_instr", instr, 16'hA5A5);
    chk("t2_valid", {15'd0, instr_valid}, 16'd1);
    chk("t2_req_drop", {15'd0, mem_req}, 16'd0);
    instr_ready = 1'b1;
    #1;
    chk("t2_upd", {15'd0, ip_update}, 16'd1);
    chk("t2_adj", ip_adj, 16'h0001);
    tick();
    instr_ready = 1'b0;
    chk("t2_valid_clr", {15'd0, instr_valid}, 16'd0);
    chk("t2_one_pulse", 16'(upd_cnt - base), 16'd1);

    // 3: decoder stalls for five cycles
    base = upd_cnt;
    ip = 16'h0011; enable = 1'b1;
    tick();
    enable = 1'b0; mem_ack = 1'b1; mem_data = 16'h1234;
    tick();
    mem_ack = 1'b0; mem_data = 16'h0BAD;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {15'd0, instr_valid}, 16'd1);
      chk("t3_hold_instr", instr, 16'h1234);
      chk("t3_hold_noupd", {15'd0, ip_update}, 16'd0);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    chk("t3_upd", {15'd0, ip_update}, 16'd1);
    tick();
    instr_ready = 1'b0;
    chk("t3_valid_clr", {15'd0, instr_valid}, 16'd0);
    chk("t3_one_pulse", 16'(upd_cnt - base), 16'd1);

    // 4: taken branch with wrap-around
    ip = 16'h0002; enable = 1'b1;
    tick();
    chk("t4_addr", mem_addr, 16'h0002);
    enable = 1'b0; mem_ack = 1'b1; mem_data = 16'h4444;
    tick();
    mem_ack = 1'b0;
    instr_ready = 1'b1; branch_take = 1'b1; branch_adj = -16'sd4;
    #1;
    chk("t4_upd", {15'd0, ip_update}, 16'd1);
    chk("t4_adj", ip_adj, 16'hFFFC);
    nip = ip + branch_adj;
    tick();
    instr_ready = 1'b0; branch_take = 1'b0; branch_adj = '0;
    ip = nip; enable = 1'b1;
    tick();
    chk("t4_wrap_addr", mem_addr, 16'hFFFE);
    // flush coinciding with the ack drops the word
    enable = 1'b0; mem_ack = 1'b1; mem_data = 16'h7777; flush = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    chk("t4_flushack_valid", {15'd0, instr_valid}, 16'd0);
    chk("t4_flushack_req", {15'd0, mem_req}, 16'd0);

    // 5: flush in REQ, ack three cycles later
    base = upd_cnt;
    ip = 16'h0100; enable = 1'b1;
    tick();
    enable = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_drain_req", {15'd0, mem_req}, 16'd0);
      chk("t5_drain_valid", {15'd0, instr_valid}, 16'd0);
      tick();
    end
    mem_ack = 1'b1; mem_data = 16'hBEEF; instr_ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5_after_ack_valid", {15'd0, instr_valid}, 16'd0);
    chk("t5_after_ack_req", {15'd0, mem_req}, 16'd0);
    tick();
    chk("t5_next_req", {15'd0, mem_req}, 16'd1);
    chk("t5_next_addr", mem_addr, 16'h0100);
    chk("t5_no_upd", 16'(upd_cnt - base), 16'd0);
    enable = 1'b0; instr_ready = 1'b0;

    // 6: flush and ready together in HOLD
    mem_ack = 1'b1; mem_data = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    chk("t6_valid", {15'd0, instr_valid}, 16'd1);
    base = upd_cnt;
    instr_ready = 1'b1; flush = 1'b1;
    #1;
    chk("t6_noupd", {15'd0, ip_update}, 16'd0);
    tick();
    instr_ready = 1'b0; flush = 1'b0;
    chk("t6_valid_clr", {15'd0, instr_valid}, 16'd0);
    chk("t6_no_pulse", 16'(upd_cnt - base), 16'd0);

    // Randomized run: the bench plays memory, decoder and IP
    ipm = 16'($urandom); have = 0; busy = 0; xfl = 0; cnt = 0; word = '0;
    for (int c = 0; c < 3000; c++) begin
      if (mem_req && !busy) begin
        chk("r_addr", mem_addr, ipm);
        busy = 1; xfl = 0; cnt = $urandom_range(0, 3);
      end
      ack = 0;
      if (busy) begin
        if (cnt == 0) ack = 1;
        else cnt--;
      end else begin
        ack = ($urandom_range(0, 7) == 0);
      end
      mem_ack = ack; mem_data = 16'($urandom);
      enable = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      branch_take = ($urandom_range(0, 3) == 0);
      branch_adj = 16'($urandom);
      ip = ipm;
      #1;
      acc = have && instr_ready && !flush;
      eadj = branch_take ? branch_adj : 16'd1;
      chk("r_valid", {15'd0, instr_valid}, {15'd0, have});
      chk("r_upd", {15'd0, ip_update}, {15'd0, acc});
      if (have) chk("r_req_in_hold", {15'd0, mem_req}, 16'd0);
      if (acc) begin
        chk("r_instr", instr, word);
        chk("r_adj", ip_adj, eadj);
        ipm = ipm + eadj;
        have = 0;
      end else if (flush) begin
        have = 0;
      end
      if (busy) begin
        if (ack) begin
          if (!xfl && !flush) begin
            have = 1;
            word = mem_data;
          end
          busy = 0;
        end else if (flush) begin
          xfl = 1;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
